// File: rtl/ddr3_user_port_arbiter.sv
// Two-requester round-robin arbiter for the DDR3 controller user command port.
// Accepted reads are tagged in order so returned data is steered to its issuer.
module ddr3_user_port_arbiter #(
    parameter int unsigned ADDRESS_BITWIDTH      = 15,
    parameter int unsigned BANK_ADDRESS_BITWIDTH = 3,
    parameter int unsigned DQ_BITWIDTH           = 16,
    parameter int unsigned MAX_OUTSTANDING_READS = 4,
    localparam int unsigned UA    = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH,
    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING_READS),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0_valid,
    input  logic                   req0_write,
    input  logic [UA-1:0]          req0_address,
    input  logic [DQ_BITWIDTH-1:0] req0_wdata,
    output logic                   req0_ready,
    output logic                   req0_rdata_valid,
    output logic [DQ_BITWIDTH-1:0] req0_rdata,
    input  logic                   req1_valid,
    input  logic                   req1_write,
    input  logic [UA-1:0]          req1_address,
    input  logic [DQ_BITWIDTH-1:0] req1_wdata,
    output logic                   req1_ready,
    output logic                   req1_rdata_valid,
    output logic [DQ_BITWIDTH-1:0] req1_rdata,
    output logic                   write_enable,
    output logic                   read_enable,
    output logic [UA-1:0]          i_user_data_address,
    output logic [DQ_BITWIDTH-1:0] i_user_data,
    input  logic                   cmd_accept,
    input  logic                   rd_data_valid,
    input  logic [DQ_BITWIDTH-1:0] o_user_data,
    output logic [CNT_W-1:0]       outstanding_reads,
    output logic                   err_unexpected_rdata
);

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t                         state;
    logic                           grant_id;
    logic                           rr_ptr;
    logic [MAX_OUTSTANDING_READS-1:0] tag_mem;
    logic [PTR_W-1:0]               wr_ptr;
    logic [PTR_W-1:0]               rd_ptr;

    logic                   fifo_full;
    logic                   elig0;
    logic                   elig1;
    logic                   sel;
    logic                   sel_write;
    logic [UA-1:0]          sel_address;
    logic [DQ_BITWIDTH-1:0] sel_wdata;
    logic                   accept;
    logic                   push;
    logic                   pop;
    logic                   head;

    // Reads are held back while the tag FIFO is full; writes never are.
    assign fifo_full = (outstanding_reads == CNT_W'(MAX_OUTSTANDING_READS));
    assign elig0     = req0_valid & (req0_write | ~fifo_full);
    assign elig1     = req1_valid & (req1_write | ~fifo_full);
    assign sel       = (elig0 & elig1) ? rr_ptr : elig1;

    assign sel_write   = sel ? req1_write   : req0_write;
    assign sel_address = sel ? req1_address : req0_address;
    assign sel_wdata   = sel ? req1_wdata   : req0_wdata;

    assign accept = (state == ISSUE) & cmd_accept;
    assign push   = accept & read_enable;
    assign pop    = rd_data_valid & (outstanding_reads != '0);
    assign head   = tag_mem[rd_ptr];

    assign req0_ready = accept & ~grant_id;
    assign req1_ready = accept &  grant_id;

    // Zero-latency steer of returned data to the requester at the tag head.
    assign req0_rdata_valid = pop & ~head;
    assign req1_rdata_valid = pop &  head;
    assign req0_rdata       = (pop & ~head) ? o_user_data : '0;
    assign req1_rdata       = (pop &  head) ? o_user_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            grant_id             <= 1'b0;
            rr_ptr               <= 1'b0;
            write_enable         <= 1'b0;
            read_enable          <= 1'b0;
            i_user_data_address  <= '0;
            i_user_data          <= '0;
            tag_mem              <= '0;
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            outstanding_reads    <= '0;
            err_unexpected_rdata <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (elig0 | elig1) begin
                        grant_id            <= sel;
                        write_enable        <= sel_write;
                        read_enable         <= ~sel_write;
                        i_user_data_address <= sel_address;
                        i_user_data         <= sel_write ? sel_wdata : '0;
                        state               <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd_accept) begin
                        write_enable <= 1'b0;
                        read_enable  <= 1'b0;
                        rr_ptr       <= ~grant_id;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) begin
                tag_mem[wr_ptr] <= grant_id;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            outstanding_reads <= outstanding_reads + CNT_W'(push) - CNT_W'(pop);

            // Data with nothing to match it is dropped and flagged.
            if (rd_data_valid && (outstanding_reads == '0) && !push) begin
                err_unexpected_rdata <= 1'b1;
            end
        end
    end

endmodule

// File: doc/ddr3_user_port_arbiter.md
Name: ddr3_user_port_arbiter

Overview:
Shares the single user command port of ddr3_memory_controller between two requesters, for example a loopback test engine and a host bridge. It uses round-robin arbitration and holds each granted command until the controller accepts it. The ID of every accepted read is tracked in order, so returned read data is steered back to the requester that issued it. It sits directly between the requesters and the controller's write_enable/read_enable/i_user_data_address/i_user_data/o_user_data pins.

Parameters:
ADDRESS_BITWIDTH, 15, DDR3 row/column address width (2GB part)
BANK_ADDRESS_BITWIDTH, 3, bank bits; user address width UA = BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH
DQ_BITWIDTH, 16, user data width (x16 part)
MAX_OUTSTANDING_READS, 4, depth of the read-ID tag FIFO; power of two, at least 2

Ports:
clk  in  1  host clock
reset  in  1  synchronous, active-high
reqN_valid (N=0,1)  in  1  requester N presents a command
reqN_write  in  1  1 = write, 0 = read
reqN_address  in  UA  user address
reqN_wdata  in  DQ_BITWIDTH  write data
reqN_ready  out  1  one-cycle pulse when requester N's command is accepted by the controller
reqN_rdata_valid  out  1  one-cycle pulse, read data for requester N
reqN_rdata  out  DQ_BITWIDTH  read data, valid with reqN_rdata_valid
write_enable  out  1  to controller
read_enable  out  1  to controller
i_user_data_address  out  UA  to controller
i_user_data  out  DQ_BITWIDTH  to controller
cmd_accept  in  1  controller consumed the command currently presented (one-cycle pulse)
rd_data_valid  in  1  controller returns one read word
o_user_data  in  DQ_BITWIDTH  controller read data
outstanding_reads  out  clog2(MAX_OUTSTANDING_READS)+1  current tag-FIFO occupancy
err_unexpected_rdata  out  1  sticky; set when read data arrives with the tag FIFO empty

Behaviour:
- Reset: all outputs are 0, FSM is in IDLE, round-robin pointer favours requester 0, tag FIFO is empty, err flag is cleared. Reset asserted in mid-operation drops the pending command and flushes the FIFO. Read data still in flight after reset is handled as unexpected.
- Requester rule: once reqN_valid is high, the requester holds reqN_valid and all its fields stable until reqN_ready. The arbiter samples the fields only when it grants.
- Eligibility: a request is eligible if it is a write, or if it is a read and occupancy < MAX_OUTSTANDING_READS. When the FIFO is full, reads wait and writes still proceed.
- FSM IDLE: if exactly one request is eligible, grant it. If both are eligible, grant the requester favoured by the pointer. The granted command is registered onto the controller outputs. write_enable = reqN_write, read_enable = ~reqN_write, and i_user_data = 0 for reads. The FSM then moves to ISSUE. The command appears on the controller pins in the cycle after the grant.
- FSM ISSUE: outputs are held until cmd_accept. In the cycle where cmd_accept=1:
  - pulse reqN_ready for the granted requester;
  - clear write_enable and read_enable on the next edge;
  - for a read, push the granted requester's ID into the FIFO;
  - move the pointer to favour the other requester;
  - return to IDLE.
- Throughput: at most one command every 2 cycles. cmd_accept is ignored while in IDLE.
- Read return: on rd_data_valid, pop the FIFO head ID. In the same cycle (combinational steer, zero latency), drive reqID_rdata_valid=1 and reqID_rdata=o_user_data. The other requester's rdata_valid stays 0.
- Simultaneous push and pop in one cycle: occupancy is unchanged, and a pop from a FIFO that is empty before the push is not allowed (the push takes effect first only for counting). Pointers wrap modulo MAX_OUTSTANDING_READS.
- rd_data_valid with the FIFO empty and no push in that cycle: drop the data, set err_unexpected_rdata, leave the FIFO unchanged.
- Requester withdraws valid in ISSUE: this is a protocol violation. The arbiter still completes the held command.

Test Plan:
- Single write: req0 writes addr 0x00005, data 0x1234. The controller pins show write_enable=1, address 0x00005, data 0x1234 one cycle after valid. cmd_accept 3 cycles later produces one req0_ready pulse, and write_enable falls on the next edge.
- Round-robin fairness: both requesters hold valid continuously and cmd_accept returns 1 cycle after each issue. Grants alternate 0,1,0,1 over 8 commands, with no requester served twice in a row.
- Read tagging: reads issued in the order req1, req0, req1 (addresses 1,2,3). rd_data_valid then returns 0xAAAA, 0xBBBB, 0xCCCC. The results are req1_rdata=0xAAAA, req0_rdata=0xBBBB, req1_rdata=0xCCCC, each with the matching rdata_valid pulse.
- FIFO full: with MAX_OUTSTANDING_READS=4 and no read return, req0 issues 4 reads and outstanding_reads=4. A 5th req0 read stalls, and a req1 write is still granted and accepted. After one rd_data_valid, the stalled read issues.
- Simultaneous push/pop at occupancy 2: the read accept and rd_data_valid occur in the same cycle, outstanding_reads stays 2, and the head ID is delivered correctly.
- Error and reset: rd_data_valid with an empty FIFO sets err_unexpected_rdata=1 and no rdata_valid pulses. Reset asserted during ISSUE with 2 reads outstanding clears all outputs and the error, and sets occupancy to 0, on the next edge.
